// File: rtl/pipeline_pkg.sv
// Shared scoreboard constants and FSM state encoding for the ID-stage hazard unit.
package pipeline_pkg;
  localparam int NUM_REGS = 32;
  localparam int CNT_W    = 2;
  localparam int TIMEOUT  = 15;
  localparam int STALL_W  = 4;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;
endpackage

// File: rtl/pipeline_scoreboard_if.sv
// Issue/retire/redirect inputs and pipeline steering outputs of the scoreboard.
interface pipeline_scoreboard_if;
  logic       issue_valid;
  logic [4:0] issue_rs;
  logic [4:0] issue_rt;
  logic       issue_uses_rt;
  logic [4:0] issue_rd;
  logic       issue_regwrite;
  logic       wb_valid;
  logic [4:0] wb_rd;
  logic       redirect;
  logic       PCWrite;
  logic       IF_ID_Write;
  logic       control;
  logic       IF_ID_flush;
  logic       stall_timeout;

  modport master (
    output issue_valid, issue_rs, issue_rt, issue_uses_rt, issue_rd, issue_regwrite,
    output wb_valid, wb_rd, redirect,
    input  PCWrite, IF_ID_Write, control, IF_ID_flush, stall_timeout
  );

  modport slave (
    input  issue_valid, issue_rs, issue_rt, issue_uses_rt, issue_rd, issue_regwrite,
    input  wb_valid, wb_rd, redirect,
    output PCWrite, IF_ID_Write, control, IF_ID_flush, stall_timeout
  );
endinterface

// File: rtl/scoreboard_counters.sv
// Per-register in-flight write counters (registers 1..31); r0 is never pending.
// SCOREBOARD_WB_BYPASS_EN: a last in-flight write retiring this cycle reads as not pending.
module scoreboard_counters
  import pipeline_pkg::*;
(
  input  logic                Clk,
  input  logic                Rst,
  input  logic                i_inc_en,
  input  logic [4:0]          i_inc_rd,
  input  logic                i_dec_en,
  input  logic [4:0]          i_dec_rd,
  output logic [NUM_REGS-1:0] o_pending,
  output logic [NUM_REGS-1:0] o_full
);

  assign o_pending[0] = 1'b0;
  assign o_full[0]    = 1'b0;

  for (genvar g = 1; g < NUM_REGS; g++) begin : g_reg
    logic [CNT_W-1:0] r_cnt;
    logic             w_inc;
    logic             w_dec;

    assign w_inc = i_inc_en && (i_inc_rd == 5'(g));
    assign w_dec = i_dec_en && (i_dec_rd == 5'(g));

    // Simultaneous issue and retire of the same register cancel out.
    always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
        r_cnt <= '0;
      end else if (w_inc && !w_dec) begin
        r_cnt <= r_cnt + 1'b1;
      end else if (w_dec && !w_inc && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end

`ifdef SCOREBOARD_WB_BYPASS_EN
    assign o_pending[g] = (r_cnt != '0) && !(w_dec && (r_cnt == CNT_W'(1)));
`else
    assign o_pending[g] = (r_cnt != '0);
`endif
    assign o_full[g] = &r_cnt;
  end

endmodule

// File: rtl/pipeline_scoreboard.sv
// ID-stage scoreboard: RAW/structural hazard detection, RUN/STALL/FLUSH steering, stall watchdog.
// Optional SCOREBOARD_WB_BYPASS_EN lets a retiring write resolve a hazard in the same cycle.
module pipeline_scoreboard
  import pipeline_pkg::*;
(
  input  logic                  Clk,
  input  logic                  Rst,
  pipeline_scoreboard_if.slave  bus
);

  state_e               r_state;
  logic [STALL_W-1:0]   r_stall_cnt;
  logic                 r_timeout;
  logic [NUM_REGS-1:0]  w_pending;
  logic [NUM_REGS-1:0]  w_full;
  logic                 w_data_haz;
  logic                 w_struct_haz;
  logic                 w_hazard;
  logic                 w_inc_en;
  logic [STALL_W-1:0]   w_stall_nxt;

  assign w_data_haz   = bus.issue_valid &&
                        (w_pending[bus.issue_rs] || (bus.issue_uses_rt && w_pending[bus.issue_rt]));
  assign w_struct_haz = bus.issue_valid && bus.issue_regwrite && w_full[bus.issue_rd];
  assign w_hazard     = w_data_haz || w_struct_haz;
  assign w_inc_en     = (r_state == ST_RUN) && bus.issue_valid && bus.issue_regwrite && !w_hazard;
  assign w_stall_nxt  = (&r_stall_cnt) ? r_stall_cnt : r_stall_cnt + 1'b1;

  scoreboard_counters u_counters (
    .Clk       (Clk),
    .Rst       (Rst),
    .i_inc_en  (w_inc_en),
    .i_inc_rd  (bus.issue_rd),
    .i_dec_en  (bus.wb_valid),
    .i_dec_rd  (bus.wb_rd),
    .o_pending (w_pending),
    .o_full    (w_full)
  );

  // Redirect is only honoured in RUN; the stall counter runs only while STALL persists.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state     <= ST_RUN;
      r_stall_cnt <= '0;
      r_timeout   <= 1'b0;
    end else begin
      r_stall_cnt <= '0;
      unique case (r_state)
        ST_RUN: begin
          if (bus.redirect)  r_state <= ST_FLUSH;
          else if (w_hazard) r_state <= ST_STALL;
        end
        ST_STALL: begin
          if (!w_hazard) begin
            r_state <= ST_RUN;
          end else begin
            r_stall_cnt <= w_stall_nxt;
            if (w_stall_nxt == STALL_W'(TIMEOUT)) r_timeout <= 1'b1;
          end
        end
        ST_FLUSH: r_state <= ST_RUN;
        default:  r_state <= ST_RUN;
      endcase
    end
  end

  // Steering follows state and the live hazard so the first hazard cycle already stalls.
  always_comb begin
    bus.PCWrite     = 1'b1;
    bus.IF_ID_Write = 1'b1;
    bus.control     = 1'b1;
    bus.IF_ID_flush = 1'b0;
    unique case (r_state)
      ST_RUN: begin
        if (w_hazard) begin
          bus.PCWrite     = 1'b0;
          bus.IF_ID_Write = 1'b0;
          bus.control     = 1'b0;
        end
      end
      ST_STALL: begin
        bus.PCWrite     = 1'b0;
        bus.IF_ID_Write = 1'b0;
        bus.control     = 1'b0;
      end
      ST_FLUSH: begin
        bus.IF_ID_Write = 1'b0;
        bus.control     = 1'b0;
        bus.IF_ID_flush = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.stall_timeout = r_timeout;

endmodule

// File: tb/tb_pipeline_scoreboard.sv
// Directed bench for pipeline_scoreboard; expectations follow SCOREBOARD_WB_BYPASS_EN when defined.
module tb_pipeline_scoreboard;
  logic Clk;
  logic Rst;
  int   n_tests;
  int   n_fail;
  logic [3:0] w_out;

  pipeline_scoreboard_if bus ();

  pipeline_scoreboard dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  assign w_out = {bus.PCWrite, bus.IF_ID_Write, bus.control, bus.IF_ID_flush};

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "bench watchdog expired");
  end

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic issue(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urt, input logic [4:0] rd, input logic rw);
    bus.issue_valid    = v;
    bus.issue_rs       = rs;
    bus.issue_rt       = rt;
    bus.issue_uses_rt  = urt;
    bus.issue_rd       = rd;
    bus.issue_regwrite = rw;
  endtask

  task automatic wb(input logic v, input logic [4:0] rd);
    bus.wb_valid = v;
    bus.wb_rd    = rd;
  endtask

  task automatic retire(input logic [4:0] rd);
    issue(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    wb(1'b1, rd);
    tick();
    wb(1'b0, 5'd0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    Rst = 1'b1;
    issue(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    wb(1'b0, 5'd0);
    bus.redirect = 1'b0;
    repeat (2) tick();
    chk("reset_outputs", w_out, 4'b1110);
    chk("reset_timeout", {3'b0, bus.stall_timeout}, 4'b0000);
    Rst = 1'b0;
    tick();

    // RAW on r5: stall until retirement
    issue(1'b1, 5'd1, 5'd2, 1'b0, 5'd5, 1'b1);
    #1 chk("raw_producer", w_out, 4'b1110);
    tick();
    issue(1'b1, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0);
    #1 chk("raw_first_cycle", w_out, 4'b0000);
    tick();
    chk("raw_stall", w_out, 4'b0000);
    tick();
    wb(1'b1, 5'd5);
    #1 chk("raw_wb_cycle", w_out, 4'b0000);
    tick();
    wb(1'b0, 5'd0);
`ifndef SCOREBOARD_WB_BYPASS_EN
    #1 chk("raw_extra_stall", w_out, 4'b0000);
    tick();
`endif
    chk("raw_resume", w_out, 4'b1110);
    issue(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();

    // r0 never pending
    issue(1'b1, 5'd3, 5'd0, 1'b0, 5'd0, 1'b1);
    #1 chk("r0_write", w_out, 4'b1110);
    tick();
    issue(1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0);
    #1 chk("r0_read_no_stall", w_out, 4'b1110);
    tick();
    chk("r0_read_still_run", w_out, 4'b1110);

    // rt only counts as a source when issue_uses_rt
    issue(1'b1, 5'd1, 5'd0, 1'b0, 5'd9, 1'b1);
    tick();
    issue(1'b1, 5'd1, 5'd9, 1'b0, 5'd9, 1'b0);
    #1 chk("rt_as_dest", w_out, 4'b1110);
    bus.issue_uses_rt = 1'b1;
    #1 chk("rt_as_source", w_out, 4'b0000);
    retire(5'd9);
    issue(1'b1, 5'd9, 5'd9, 1'b1, 5'd0, 1'b0);
    #1 chk("rt_cleared", w_out, 4'b1110);

    // Structural hazard on the fourth in-flight write to r7
    for (int i = 0; i < 3; i++) begin
      issue(1'b1, 5'd1, 5'd0, 1'b0, 5'd7, 1'b1);
      #1 chk("struct_fill", w_out, 4'b1110);
      tick();
    end
    #1 chk("struct_hazard", w_out, 4'b0000);
    tick();
    chk("struct_stall", w_out, 4'b0000);
    wb(1'b1, 5'd7);
    #1 chk("struct_wb_cycle", w_out, 4'b0000);
    tick();
    wb(1'b0, 5'd0);
    #1 chk("struct_leave_stall", w_out, 4'b0000);
    tick();
    chk("struct_issue", w_out, 4'b1110);
    tick();
    repeat (4) retire(5'd7);
    issue(1'b1, 5'd7, 5'd0, 1'b0, 5'd0, 1'b0);
    #1 chk("dec_at_zero_holds", w_out, 4'b1110);

    // Simultaneous issue and retire of r11 leaves the count at 1
    issue(1'b1, 5'd1, 5'd0, 1'b0, 5'd11, 1'b1);
    tick();
    wb(1'b1, 5'd11);
    tick();
    wb(1'b0, 5'd0);
    issue(1'b1, 5'd11, 5'd0, 1'b0, 5'd0, 1'b0);
    #1 chk("inc_dec_same_reg", w_out, 4'b0000);
    retire(5'd11);
    issue(1'b1, 5'd11, 5'd0, 1'b0, 5'd0, 1'b0);
    #1 chk("inc_dec_then_retire", w_out, 4'b1110);

    // Redirect wins over a simultaneous hazard
    issue(1'b1, 5'd1, 5'd0, 1'b0, 5'd12, 1'b1);
    tick();
    issue(1'b1, 5'd12, 5'd0, 1'b0, 5'd0, 1'b0);
    bus.redirect = 1'b1;
    tick();
    bus.redirect = 1'b0;
    chk("flush_outputs", w_out, 4'b1001);
    tick();
    chk("flush_then_run_hazard", w_out, 4'b0000);
    tick();
    chk("flush_then_stall", w_out, 4'b0000);
    retire(5'd12);
    tick();
    chk("flush_recover", w_out, 4'b1110);

    // No counter increment during FLUSH
    bus.redirect = 1'b1;
    tick();
    bus.redirect = 1'b0;
    issue(1'b1, 5'd1, 5'd0, 1'b0, 5'd13, 1'b1);
    #1 chk("flush_with_issue", w_out, 4'b1001);
    tick();
    retire(5'd13);
    issue(1'b1, 5'd13, 5'd0, 1'b0, 5'd0, 1'b0);
    #1 chk("flush_no_inc", w_out, 4'b1110);

    // Watchdog: sets after 15 consecutive STALL cycles, then sticks
    issue(1'b1, 5'd1, 5'd0, 1'b0, 5'd20, 1'b1);
    tick();
    issue(1'b1, 5'd20, 5'd0, 1'b0, 5'd0, 1'b0);
    repeat (15) tick();
    chk("timeout_not_yet", {3'b0, bus.stall_timeout}, 4'b0000);
    tick();
    chk("timeout_set", {3'b0, bus.stall_timeout}, 4'b0001);
    retire(5'd20);
    repeat (2) tick();
    chk("timeout_sticky", {3'b0, bus.stall_timeout}, 4'b0001);
    chk("timeout_run_again", w_out, 4'b1110);

    // Asynchronous reset in the middle of a STALL
    issue(1'b1, 5'd1, 5'd0, 1'b0, 5'd22, 1'b1);
    tick();
    issue(1'b1, 5'd22, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    chk("pre_reset_stall", w_out, 4'b0000);
    #2 Rst = 1'b1;
    #1 chk("async_reset_outputs", w_out, 4'b1110);
    chk("async_reset_timeout", {3'b0, bus.stall_timeout}, 4'b0000);
    Rst = 1'b0;
    tick();
    chk("reset_cleared_counters", w_out, 4'b1110);
    issue(1'b1, 5'd20, 5'd22, 1'b1, 5'd0, 1'b0);
    #1 chk("reset_cleared_all", w_out, 4'b1110);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
